register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/regfile_pkg.sv | 16 +
 rtl/register_file_if.sv | 39 +++
 rtl/regfile_clear_seq.sv | 53 +++++
 rtl/register_file.sv | 73 +++++++
 tb/tb_register_file.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state type and address-width helper for the register file.
// Contents:
//   fsmState_t - CLEAR (zeroing walk in progress) / READY (normal operation)
//   addrWidth  - bits needed to index DEPTH registers (at least 1)
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } fsmState_t;

    function automatic int addrWidth(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/register_file_if.sv
// register_file_if: bus bundle between a register file and its user.
// Signals:
//   clearRequest - one-cycle pulse starting a full clear sequence
//   writeEnable  - write strobe
//   writeAddr    - write index (AW bits)
//   writeData    - write value (WIDTH bits)
//   readAddr     - packed read indices, port 0 in the LSBs
//   readData     - packed read values, port 0 in the LSBs
//   tapData      - packed debug tap values
//   busy         - high while the clear sequence runs
// Modports: master drives requests and addresses, slave (the register file) drives data and busy.
interface register_file_if #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int READ_PORTS = 2,
    parameter int TAPS       = 3
) ();
    localparam int AW = regfile_pkg::addrWidth(DEPTH);

    logic                       clearRequest;
    logic                       writeEnable;
    logic [AW-1:0]              writeAddr;
    logic [WIDTH-1:0]           writeData;
    logic [READ_PORTS*AW-1:0]   readAddr;
    logic [READ_PORTS*WIDTH-1:0] readData;
    logic [TAPS*WIDTH-1:0]      tapData;
    logic                       busy;

    modport master (
        output clearRequest, writeEnable, writeAddr, writeData, readAddr,
        input  readData, tapData, busy
    );

    modport slave (
        input  clearRequest, writeEnable, writeAddr, writeData, readAddr,
        output readData, tapData, busy
    );

endinterface

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: CLEAR/READY sequencer that walks every register index once after reset or a clear request.
// Ports:
//   clk          - clock, rising edge
//   resetN       - asynchronous active-low reset, forces CLEAR with index 0
//   clearRequest - restarts the walk when seen in READY; ignored while clearing
//   clearIdx     - register index being zeroed this cycle
//   busy         - high in CLEAR
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = addrWidth(DEPTH)
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          clearRequest,
    output logic [AW-1:0] clearIdx,
    output logic          busy
);

    fsmState_t     state, nextState;
    logic [AW-1:0] nextIdx;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= CLEAR;
            clearIdx <= '0;
        end else begin
            state    <= nextState;
            clearIdx <= nextIdx;
        end
    end

    // The edge that zeroes the last register is also the edge that leaves CLEAR,
    // so a walk always takes exactly DEPTH cycles.
    always_comb begin
        nextState = state;
        nextIdx   = clearIdx;
        if (state == CLEAR) begin
            nextIdx = clearIdx + 1'b1;
            if (clearIdx == AW'(DEPTH - 1)) begin
                nextState = READY;
                nextIdx   = '0;
            end
        end else if (clearRequest) begin
            nextState = CLEAR;
            nextIdx   = '0;
        end
    end

    assign busy = (state == CLEAR);

endmodule

// File: rtl/register_file.sv
// register_file: multi-port register file with hardwired-zero register 0, clear sequencer and debug taps.
// Ports:
//   clk    - clock, all state changes on its rising edge
//   resetN - asynchronous active-low reset; restarts the clear sequence
//   bus    - register_file_if.slave: clearRequest, writeEnable/writeAddr/writeData,
//            readAddr/readData (combinational reads), tapData (registers TAP_BASE..TAP_BASE+TAPS-1), busy
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle write to matching read ports.
module register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int READ_PORTS = 2,
    parameter int TAPS       = 3,
    parameter int TAP_BASE   = 2
) (
    input  logic           clk,
    input  logic           resetN,
    register_file_if.slave bus
);

    localparam int AW = addrWidth(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [AW-1:0]    clearIdx;
    logic             busy;
    logic             writeValid;
    logic             writeFire;

    regfile_clear_seq #(.DEPTH(DEPTH), .AW(AW)) clearSeq (
        .clk          (clk),
        .resetN       (resetN),
        .clearRequest (bus.clearRequest),
        .clearIdx     (clearIdx),
        .busy         (busy)
    );

    assign bus.busy   = busy;
    assign writeValid = (bus.writeAddr != '0) && (int'(bus.writeAddr) < DEPTH);
    // An accepted clear request takes priority over a coincident write.
    assign writeFire  = !busy && bus.writeEnable && !bus.clearRequest && writeValid;

    // Storage needs no reset: outputs are masked while busy and the walk zeroes every entry.
    always_ff @(posedge clk) begin
        if (busy)
            regs[clearIdx] <= '0;
        else if (writeFire)
            regs[bus.writeAddr] <= bus.writeData;
    end

    for (genvar r = 0; r < READ_PORTS; r++) begin : gRead
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] stored;
        assign addr   = bus.readAddr[r*AW +: AW];
        assign stored = (addr == '0 || int'(addr) >= DEPTH) ? '0 : regs[addr];
`ifdef REGFILE_BYPASS_EN
        assign bus.readData[r*WIDTH +: WIDTH] = busy ? '0 :
                                                (writeFire && addr == bus.writeAddr) ? bus.writeData : stored;
`else
        assign bus.readData[r*WIDTH +: WIDTH] = busy ? '0 : stored;
`endif
    end

    for (genvar t = 0; t < TAPS; t++) begin : gTap
        localparam int IDX = TAP_BASE + t;
        if (IDX > 0 && IDX < DEPTH) begin : gLive
            assign bus.tapData[t*WIDTH +: WIDTH] = busy ? '0 : regs[IDX];
        end else begin : gZero
            assign bus.tapData[t*WIDTH +: WIDTH] = '0;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed, table-driven bench for register_file (DEPTH=32 and DEPTH=20 instances).
module tb_register_file;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic resetN20 = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    register_file_if #(.WIDTH(32), .DEPTH(32), .READ_PORTS(2), .TAPS(3)) b32 ();
    register_file_if #(.WIDTH(32), .DEPTH(20), .READ_PORTS(2), .TAPS(3)) b20 ();

    register_file #(.WIDTH(32), .DEPTH(32), .READ_PORTS(2), .TAPS(3), .TAP_BASE(2)) dut32 (
        .clk    (clk),
        .resetN (resetN),
        .bus    (b32)
    );

    register_file #(.WIDTH(32), .DEPTH(20), .READ_PORTS(2), .TAPS(3), .TAP_BASE(18)) dut20 (
        .clk    (clk),
        .resetN (resetN20),
        .bus    (b20)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic cr, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic [4:0] ra0, input logic [4:0] ra1);
        b32.clearRequest = cr;
        b32.writeEnable  = we;
        b32.writeAddr    = wa;
        b32.writeData    = wd;
        b32.readAddr     = {ra1, ra0};
    endtask

    task automatic drive20(input logic cr, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic [4:0] ra0, input logic [4:0] ra1);
        b20.clearRequest = cr;
        b20.writeEnable  = we;
        b20.writeAddr    = wa;
        b20.writeData    = wd;
        b20.readAddr     = {ra1, ra0};
    endtask

    // Counts edges until busy drops (bounded); optionally pulses clearRequest once mid-walk.
    task automatic countBusy32(input int pulseAt, output int n, output logic bad);
        n = 0;
        bad = 1'b0;
        while (b32.busy === 1'b1 && n < 200) begin
            if (b32.readData !== '0 || b32.tapData !== '0) bad = 1'b1;
            b32.clearRequest = (n == pulseAt);
            tick();
            n++;
        end
        b32.clearRequest = 1'b0;
    endtask

    task automatic countBusy20(output int n, output logic bad);
        n = 0;
        bad = 1'b0;
        while (b20.busy === 1'b1 && n < 200) begin
            if (b20.readData !== '0 || b20.tapData !== '0) bad = 1'b1;
            tick();
            n++;
        end
    endtask

    initial begin
        int          n;
        logic        bad;
        logic [31:0] bypassExp;

        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[1] = '{1'b1, 5'd0, 32'h00001234, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[3] = '{1'b1, 5'd2, 32'd7,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[4] = '{1'b1, 5'd3, 32'd8,        5'd2,  5'd31, 32'd7,        32'h0};
        vecs[5] = '{1'b1, 5'd4, 32'd9,        5'd3,  5'd2,  32'd8,        32'd7};
        vecs[6] = '{1'b0, 5'd4, 32'h0,        5'd4,  5'd3,  32'd9,        32'd8};

        drive32(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
        drive20(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #2;
        check("reset_busy", 128'(b32.busy), 128'(1'b1));
        check("reset_read", 128'(b32.readData), 128'h0);
        check("reset_tap", 128'(b32.tapData), 128'h0);

        tick();
        resetN = 1'b1;
        countBusy32(-1, n, bad);
        check("reset_clear_len", 128'(n), 128'd32);
        check("clear_outputs_zero", 128'(bad), 128'h0);
        check("ready_busy", 128'(b32.busy), 128'h0);

`ifdef REGFILE_BYPASS_EN
        bypassExp = 32'hA5A5A5A5;
`else
        bypassExp = 32'h0;
`endif
        drive32(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd0);
        #1;
        check("bypass_same_cycle", 128'(b32.readData[31:0]), 128'(bypassExp));
        tick();
        drive32(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        #1;
        check("after_write_reg3", 128'(b32.readData), {64'h0, 32'hA5A5A5A5, 32'hA5A5A5A5});
        drive32(1'b0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
        #1;
        check("write0_no_forward", 128'(b32.readData), 128'h0);
        tick();

        for (int i = 0; i < 7; i++) begin
            drive32(1'b0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra0, vecs[i].ra1);
            #1;
            check($sformatf("vec%0d", i), 128'(b32.readData), {64'h0, vecs[i].exp1, vecs[i].exp0});
            tick();
        end
        drive32(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #1;
        check("tap_values", 128'(b32.tapData), {32'h0, 32'd9, 32'd8, 32'd7});

        drive32(1'b1, 1'b1, 5'd6, 32'h55, 5'd6, 5'd5);
        tick();
        drive32(1'b0, 1'b0, 5'd0, 32'h0, 5'd6, 5'd5);
        check("clear_busy", 128'(b32.busy), 128'(1'b1));
        countBusy32(10, n, bad);
        check("clear_len_with_repulse", 128'(n), 128'd32);
        check("clear_outputs_zero2", 128'(bad), 128'h0);
        #1;
        check("clear_dropped_write", 128'(b32.readData), 128'h0);
        check("clear_taps", 128'(b32.tapData), 128'h0);

        resetN20 = 1'b1;
        countBusy20(n, bad);
        check("d20_clear_len", 128'(n), 128'd20);
        drive20(1'b0, 1'b1, 5'd19, 32'h77, 5'd0, 5'd0);
        tick();
        drive20(1'b0, 1'b1, 5'd18, 32'h66, 5'd0, 5'd0);
        tick();
        drive20(1'b0, 1'b1, 5'd25, 32'hBAD, 5'd25, 5'd19);
        #1;
        check("d20_read_oob", 128'(b20.readData), {64'h0, 32'h77, 32'h0});
        tick();
        drive20(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
        #1;
        check("d20_no_alias", 128'(b20.readData), 128'h0);
        check("d20_taps_clamped", 128'(b20.tapData), {32'h0, 32'h0, 32'h77, 32'h66});
        drive20(1'b0, 1'b0, 5'd0, 32'h0, 5'd25, 5'd18);
        #1;
        check("d20_read_oob2", 128'(b20.readData), {64'h0, 32'h66, 32'h0});

        drive20(1'b1, 1'b0, 5'd0, 32'h0, 5'd19, 5'd18);
        tick();
        drive20(1'b0, 1'b0, 5'd0, 32'h0, 5'd19, 5'd18);
        repeat (6) tick();
        resetN20 = 1'b0;
        #2;
        check("d20_reset_busy", 128'(b20.busy), 128'(1'b1));
        check("d20_reset_read", 128'(b20.readData), 128'h0);
        resetN20 = 1'b1;
        countBusy20(n, bad);
        check("d20_restart_len", 128'(n), 128'd20);
        check("d20_clear_outputs_zero", 128'(bad), 128'h0);
        #1;
        check("d20_cleared", 128'(b20.readData), 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
